// File: rtl/board_pkg.sv
// Shared widths, colour codes and enums for the board RAM scheduler.
package board_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 3;
  localparam int unsigned DEPTH  = 32768;

  localparam logic [DATA_W-1:0] EMPTY = 3'd0;
  localparam logic [DATA_W-1:0] P1    = 3'd1;
  localparam logic [DATA_W-1:0] P2    = 3'd2;
  localparam logic [DATA_W-1:0] P3    = 3'd4;
  localparam logic [DATA_W-1:0] P4    = 3'd6;
  localparam logic [DATA_W-1:0] CRASH = 3'd7;

  typedef enum logic [1:0] {TAG_NONE, TAG_GAME, TAG_DRAW} req_tag_e;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;

endpackage

// File: rtl/board_clear_sweep.sv
// Board-clear sequencer: walks every cell address once and pulses done afterwards.
module board_clear_sweep
  import board_pkg::*;
#(
  parameter int unsigned ADDR_W         = board_pkg::ADDR_W,
  parameter int unsigned DEPTH          = board_pkg::DEPTH,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_start_i,
  output logic              idle_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  // One extra bit so DEPTH == 2**ADDR_W still reaches the terminal count.
  localparam int unsigned      CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

  clr_state_e       state_q;
  logic [CNT_W-1:0] clr_addr_q;
  logic             done_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (clear_start_i) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
          end
        end
        CLEAR: begin
          clr_addr_q <= clr_addr_q + CNT_W'(1);
          if (clr_addr_q == LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign idle_o     = (state_q == IDLE);
  assign busy_o     = (state_q == CLEAR);
  assign done_o     = done_q;
  assign clr_addr_o = clr_addr_q[ADDR_W-1:0];

endmodule

// File: rtl/board_ram_scheduler.sv
// Single-port board RAM owner: clear sweep, game/draw arbitration and read-tag return.
module board_ram_scheduler
  import board_pkg::*;
#(
  parameter int unsigned ADDR_W         = board_pkg::ADDR_W,
  parameter int unsigned DATA_W         = board_pkg::DATA_W,
  parameter int unsigned DEPTH          = board_pkg::DEPTH,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned STARVE_MAX     = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              g_req,
  input  logic              g_we,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [DATA_W-1:0] g_wdata,
  output logic              g_gnt,
  output logic              g_rvalid,
  output logic [DATA_W-1:0] g_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int unsigned      STV_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STV_W-1:0] STV_LIM = STV_W'(STARVE_MAX);

  logic              clr_idle;
  logic [ADDR_W-1:0] clr_addr;
  logic              arb_en;
  logic              d_force;
  logic [STV_W-1:0]  starve_q, starve_d;
  req_tag_e          tag_q, tag_d;
  logic              g_rvalid_q, d_rvalid_q;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;

  board_clear_sweep #(
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_sweep (
    .clk_i         (CLOCK_50),
    .reset_i       (reset),
    .clear_start_i (clear_start),
    .idle_o        (clr_idle),
    .busy_o        (clear_busy),
    .done_o        (clear_done),
    .clr_addr_o    (clr_addr)
  );

  // Game wins by default; a draw that has lost STARVE_MAX times in a row wins once.
  assign arb_en  = clr_idle & ~reset;
  assign d_force = (starve_q == STV_LIM);
  assign g_gnt   = arb_en & g_req & ~(d_req & d_force);
  assign d_gnt   = arb_en & d_req & (~g_req | d_force);

  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wren_d = 1'b0;
    tag_d      = TAG_NONE;
    starve_d   = starve_q;
    if (clear_busy) begin
      ram_addr_d = clr_addr;
      ram_data_d = '0;
      ram_wren_d = 1'b1;
    end else if (g_gnt) begin
      ram_addr_d = g_addr;
      ram_data_d = g_wdata;
      ram_wren_d = g_we;
      tag_d      = g_we ? TAG_NONE : TAG_GAME;
    end else if (d_gnt) begin
      ram_addr_d = d_addr;
      tag_d      = TAG_DRAW;
    end
    if (d_gnt) begin
      starve_d = '0;
    end else if (d_req && (starve_q != STV_LIM)) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // Tag stage 1 rides with ram_address, stage 2 lines up with ram_q.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
      starve_q   <= '0;
      tag_q      <= TAG_NONE;
      g_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wren_q <= ram_wren_d;
      starve_q   <= starve_d;
      tag_q      <= tag_d;
      g_rvalid_q <= (tag_q == TAG_GAME);
      d_rvalid_q <= (tag_q == TAG_DRAW);
    end
  end

  assign ram_address = ram_addr_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign g_rvalid    = g_rvalid_q;
  assign d_rvalid    = d_rvalid_q;
  assign g_rdata     = ram_q;
  assign d_rdata     = ram_q;

endmodule

// File: doc/board_ram_scheduler.md
Name: board_ram_scheduler

Overview:
Owns the single port of the 32768x3 board RAM and shares it between three users:
- an internal board-clear sweep;
- the game update engine, which does per-tick player read/collision/write;
- the VGA draw reader.

It issues at most one RAM access per CLOCK_50 cycle and returns read data tagged to the requester that issued it. It sits between game/ram_update, the draw controller and the RAM instance. It makes board reset (new game) a hardware sequence instead of relying on RAM power-up contents.

Parameters:
ADDR_W, 15, RAM address width (8 X bits, 7 Y bits)
DATA_W, 3, RAM cell width (colour code)
DEPTH, 32768, number of cells swept by a clear
CLEAR_ON_RESET, 1, 1 = enter CLEAR automatically when reset deasserts
STARVE_MAX, 8, consecutive cycles a pending draw request may lose before it is forced to win

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
clear_start  in  1  one-cycle pulse: begin board clear
clear_busy  out  1  high while the sweep owns the RAM
clear_done  out  1  one-cycle pulse after the last clear write is issued
g_req  in  1  game access request
g_we  in  1  1 = write, 0 = read
g_addr  in  ADDR_W  game address
g_wdata  in  DATA_W  game write data
g_gnt  out  1  game request accepted this cycle (combinational)
g_rvalid  out  1  game read data valid
g_rdata  out  DATA_W  game read data
d_req  in  1  draw read request (read only)
d_addr  in  ADDR_W  draw address
d_gnt  out  1  draw request accepted this cycle (combinational)
d_rvalid  out  1  draw read data valid
d_rdata  out  DATA_W  draw read data
ram_address  out  ADDR_W  registered RAM address
ram_data  out  DATA_W  registered RAM write data
ram_wren  out  1  registered RAM write enable
ram_q  in  DATA_W  RAM read data (synchronous RAM, q valid one cycle after the address is latched)

Behaviour:
- Reset (reset=1 at an edge):
  - ram_wren=0, ram_address=0, ram_data=0.
  - g_gnt=d_gnt=0, g_rvalid=d_rvalid=0, clear_done=0, starve counter=0, read-tag pipeline flushed.
  - State <= CLEAR with clr_addr=0 if CLEAR_ON_RESET, else IDLE.
  - Reset mid-clear restarts the sweep at address 0; reset mid-read drops that rvalid.
- FSM states and transitions:
  - IDLE: clear_start -> CLEAR (clr_addr=0).
  - CLEAR: each cycle registers ram_wren=1, ram_address=clr_addr, ram_data=0, and clr_addr++. When an edge issues clr_addr==DEPTH-1 -> DONE.
  - DONE: clear_done=1 for one cycle -> IDLE.
  - clear_start in CLEAR or DONE is ignored.
  - clear_busy=1 in CLEAR only. g_gnt=d_gnt=0 in CLEAR and DONE.
- Arbitration (IDLE only):
  - Handshake: a request is accepted in a cycle where req=1 and gnt=1. The requester holds addr/we/wdata stable until gnt and may present a new request the cycle after.
  - Default priority is game over draw.
  - Starve counter: increments when d_req=1 and d_gnt=0, clears on d_gnt. When the counter equals STARVE_MAX, draw wins that cycle even if g_req=1.
  - Winner's request is registered onto ram_* at the end of the grant cycle. A draw request always has ram_wren=0.
  - No winner: ram_wren<=0 and ram_address/ram_data hold.
- Read latency:
  - A read granted in cycle N has ram_address valid in N+1 and ram_q valid in N+2.
  - rvalid is asserted in N+2 for exactly the granted requester (2-stage tag pipeline).
  - g_rdata=d_rdata=ram_q (unregistered); meaningful only while the matching rvalid is high.
  - Back-to-back reads are granted every cycle.
  - Game writes produce no rvalid.
- Read-after-write: a game write in N followed by a read of the same address granted in N+1 returns the new data in N+3.
- Addresses are ADDR_W wide with no wrap logic. The clear counter is ADDR_W+1 bits so that DEPTH=2^ADDR_W terminates correctly.

Decomposition:
- Package board_pkg:
  - ADDR_W, DATA_W, DEPTH.
  - Colour constants: EMPTY=0, P1=1, P2=2, P3=4, P4=6, CRASH=7.
  - Requester tag enum {TAG_NONE, TAG_GAME, TAG_DRAW}.
  - Clear FSM state enum {IDLE, CLEAR, DONE}.
- One sub-module, board_clear_sweep: owns the clear FSM, clr_addr, clear_busy and clear_done. Arbiter, starve counter and tag pipeline stay in the top.

Test Plan:
1. Release reset, CLEAR_ON_RESET=1, DEPTH=16 -> ram_wren=1 and ram_data=0 on addresses 0..15 for 16 consecutive cycles; clear_done pulse follows; g_gnt stays 0 although g_req=1 throughout.
2. IDLE, game writes 0x1234<=3'b001, then reads 0x1234 the next cycle -> g_gnt both cycles; g_rvalid=1 with g_rdata=3'b001 two cycles after the read grant.
3. g_req and d_req held high continuously, STARVE_MAX=8 -> game granted 8 cycles, draw granted on the 9th, pattern repeats; d_rvalid/g_rvalid tags never swap.
4. Draw-only streaming reads of addresses 0..4 -> d_gnt every cycle; d_rvalid high 5 consecutive cycles starting 2 cycles after the first grant, with data in order.
5. clear_start asserted with a game read granted the same cycle -> read completes with g_rvalid; sweep starts next cycle; second clear_start during CLEAR ignored (exactly one clear_done).
6. reset asserted at clr_addr=7 -> all outputs zero; sweep restarts at address 0 after reset releases; no stale rvalid.
